regfile_wr_arbiter: RTL



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/rf_scoreboard.sv | 52 +++++
 rtl/regfile_wr_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Register file constants and write-request types.                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int          NUM_REGS   = 15;
    localparam int          REG_ADDR_W = 4;
    localparam int          RF_DATA_W  = 32;
    localparam int          CNT_W      = 4;
    localparam logic [3:0]  PC_REG     = 4'd15;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic                 we;
        reg_addr_t            wa;
        logic [RF_DATA_W-1:0] wd;
    } rf_wr_t;

    // r15 is the PC and has no storage in the register file.
    function automatic logic is_pc(input reg_addr_t a);
        return a == PC_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_scoreboard                                                        |
// | Busy bits for registers awaiting a coprocessor write; RAW lookup.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module rf_scoreboard
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  reg_addr_t           set_wa,
    input  logic                clr_en,
    input  reg_addr_t           clr_wa,
    input  reg_addr_t           rd_a1,
    input  reg_addr_t           rd_a2,
    output logic [NUM_REGS-1:0] busy,
    output logic                hz_stall
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [15:0]         w_busy_ext;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_en && (clr_wa == reg_addr_t'(i))) begin
                busy_d[i] = 1'b0;
            end
            // Applied after the clear so a same-cycle reserve wins.
            if (set_en && (set_wa == reg_addr_t'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign w_busy_ext = {1'b0, busy_q};
    assign busy       = busy_q;
    assign hz_stall   = w_busy_ext[rd_a1] | w_busy_ext[rd_a2];

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wr_arbiter                                                   |
// | Shares the register file write port between writeback (priority) and |
// | a buffered coprocessor result with starvation forcing.               |
// | Optional scoreboard: define REGFILE_ARB_SCOREBOARD_EN.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module regfile_wr_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_we,
    input  logic [3:0]          wb_wa,
    input  logic [DATA_W-1:0]   wb_wd,
    output logic                wb_stall,
    input  logic                mc_valid,
    output logic                mc_ready,
    input  logic [3:0]          mc_wa,
    input  logic [DATA_W-1:0]   mc_wd,
    input  logic                rsv_valid,
    input  logic [3:0]          rsv_wa,
    input  logic [3:0]          rd_a1,
    input  logic [3:0]          rd_a2,
    output logic                hz_stall,
    output logic [NUM_REGS-1:0] busy,
    output logic                we3,
    output logic [3:0]          wa3,
    output logic [DATA_W-1:0]   wd3
);

    // DATA_W must not exceed RF_DATA_W; the request struct carries RF_DATA_W bits.
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic              full_q, full_d;
    reg_addr_t         addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    logic   w_force;
    logic   w_accept;
    logic   w_buf_commit;
    logic   w_wb_stall;
    rf_wr_t w_sel;

    assign mc_ready = !full_q && !rst;
    assign w_accept = mc_valid && mc_ready;
    assign w_force  = full_q && (cnt_q == STARVE_LIM);

    always_comb begin
        w_sel        = '0;
        w_buf_commit = 1'b0;
        w_wb_stall   = 1'b0;
        if (rst) begin
            w_sel = '0;
        end else if (w_force) begin
            w_sel.we     = 1'b1;
            w_sel.wa     = addr_q;
            w_sel.wd     = RF_DATA_W'(data_q);
            w_buf_commit = 1'b1;
            w_wb_stall   = wb_we;
        end else if (wb_we) begin
            w_sel.we = 1'b1;
            w_sel.wa = wb_wa;
            w_sel.wd = RF_DATA_W'(wb_wd);
        end else if (full_q) begin
            w_sel.we     = 1'b1;
            w_sel.wa     = addr_q;
            w_sel.wd     = RF_DATA_W'(data_q);
            w_buf_commit = 1'b1;
        end
    end

    // A PC-targeted write is dropped here but still counts as committed upstream.
    assign we3      = w_sel.we && !is_pc(w_sel.wa);
    assign wa3      = w_sel.wa;
    assign wd3      = w_sel.wd[DATA_W-1:0];
    assign wb_stall = w_wb_stall;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (w_buf_commit) begin
            full_d = 1'b0;
        end else if (w_accept) begin
            full_d = 1'b1;
            addr_d = mc_wa;
            data_d = mc_wd;
        end
        if (!full_q || w_buf_commit) begin
            cnt_d = '0;
        end else if (wb_we && (cnt_q != STARVE_LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef REGFILE_ARB_SCOREBOARD_EN
    logic w_sb_hz;

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (rsv_valid),
        .set_wa   (rsv_wa),
        .clr_en   (w_buf_commit),
        .clr_wa   (addr_q),
        .rd_a1    (rd_a1),
        .rd_a2    (rd_a2),
        .busy     (busy),
        .hz_stall (w_sb_hz)
    );

    assign hz_stall = w_sb_hz && !rst;
`else
    logic w_unused_sb;

    assign w_unused_sb = ^{rsv_valid, rsv_wa, rd_a1, rd_a2};
    assign busy        = '0;
    assign hz_stall    = 1'b0;
`endif

endmodule
`default_nettype wire
